rr_arbiter_n: RTL and testbench
===============================

# rr_arbiter_n

Parametrised round-robin arbiter for N requesters with registered one-hot grant plus binary grant index. It is the sequential successor of the N-bit MSB priority encoder: a rotating-priority encoder core with a pointer register, so every requester is served fairly. It sits between N bus masters and one shared resource, and optionally holds a grant across multi-cycle bursts.

## Interface
- N, default 4: number of requesters, N ≥ 1.
- IDX_W, derived (not overridable): 1 if N == 1, else $clog2(N).
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector; bit i set means requester i wants the resource.
- lock  input  N  bit i held high extends requester i's current grant; ignored unless ARB_LOCK_EN is defined.
- gnt  output  N  registered one-hot grant; all zeros when no grant.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_idx  output  IDX_W  registered binary index of the granted requester; 0 when gnt_valid is 0.

## Operation
- Pointer register ptr (IDX_W bits) holds the highest-priority index for the next arbitration.
- Search order is ptr, ptr+1, …, N-1, 0, …, ptr-1. The first set req bit in that order wins.
- State machine, states IDLE, GRANT and LOCKED (LOCKED exists only when ARB_LOCK_EN is defined):
  - IDLE: req == 0 → stay in IDLE with outputs zero. req != 0 → arbitrate, register the winner, go to GRANT.
  - GRANT: each grant lasts exactly one cycle. Re-arbitrate every cycle: req != 0 → new winner (may be the same index only if no other requester is set), stay in GRANT. req == 0 → IDLE.
  - With ARB_LOCK_EN, GRANT → LOCKED when both req[w] and lock[w] are high for the current winner w.
  - LOCKED: gnt is held unchanged while req[w] && lock[w]. When either drops, re-arbitrate in the same cycle: go to GRANT with a new winner, or to IDLE.
- On every new grant to index w: ptr ← (w == N-1) ? 0 : w+1. The pointer does not change while LOCKED.
- Index arithmetic is mod N, not mod 2^IDX_W. This matters when N is not a power of 2: for N=5, after w=4 the pointer goes to 0, never to 5..7.
- N == 1: gnt = req registered, gnt_idx always 0, ptr is constant 0.
- Requests are level-sensitive. A requester that drops req is simply not selected in the next search; no queued history is kept.

## Timing
- Reset (asserted asynchronously): gnt=0, gnt_valid=0, gnt_idx=0, ptr=0, state IDLE. These values hold until the first rising edge after deassertion.
- Latency: req sampled at edge k is reflected in gnt, gnt_valid and gnt_idx immediately after edge k. Combinational req-to-gnt path is zero; outputs are pure registers.
- gnt, gnt_valid and gnt_idx always change together on the same edge.
- Reset asserted during LOCKED drops the grant and pointer immediately, without waiting for a clock edge.
- Same-cycle drop of lock and rise of another req: the new requester is eligible in that same arbitration.

## Configuration
- ARB_LOCK_EN defined: the LOCKED state and the lock input are active, giving burst hold.
- ARB_LOCK_EN undefined: the lock port still exists but is unused, the LOCKED state is not built, and every grant lasts one cycle.

## Structure
- Package rr_arb_pkg:
  - state enum arb_state_t (IDLE, GRANT, LOCKED);
  - function idx_w(n) returning 1 when n ≤ 1, else $clog2(n);
  - constant-free helpers only.
- Sub-module rot_prio_enc_n: combinational rotating priority encoder with inputs req and ptr, and outputs winner one-hot, winner index and any. It is parametrised by N and is reused by other arbiters.
- rr_arbiter_n holds the registers, state machine and pointer update.

## Test plan
- N=4, reset, then req=4'b1111 held for 4 cycles → gnt_idx sequence 0,1,2,3, then 0 again; gnt_valid=1 throughout.
- N=4, req=4'b1010 with ptr=0 → grants alternate 1,3,1,3; gnt is never 4'b0101-side.
- N=5, req=5'b10001 → grants 0,4,0,4; ptr is observed to wrap from 4 to 0, never reaching 5.
- ARB_LOCK_EN, N=4: req=4'b0011 with lock[0]=1 for 3 cycles → gnt=4'b0001 held for 3 cycles; lock[0]=0 → next grant is idx 1.
- Reset asserted mid-LOCKED between clock edges → outputs are 0 before the next edge; first grant after release uses ptr=0.
- N=1: req toggles 1,0,1 → gnt_valid follows 1 cycle later, gnt_idx always 0.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// ---------------------------------------------------------------------------
// rr_arb_pkg
// Shared types and helpers for the round-robin arbiter family.
//   arb_state_t : arbiter state machine encoding (IDLE, GRANT, LOCKED).
//                 LOCKED is only reachable when ARB_LOCK_EN is defined.
//   idx_w(n)    : width of a binary index for n requesters; 1 when n <= 1,
//                 else $clog2(n).
// ---------------------------------------------------------------------------
package rr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  // A single requester still needs a 1-bit index port so the interface never
  // collapses to a zero-width vector.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rot_prio_enc_n.sv
// ---------------------------------------------------------------------------
// rot_prio_enc_n
// Combinational rotating priority encoder. Searches req_i starting at ptr_i
// and wrapping modulo N (ptr_i, ptr_i+1, ..., N-1, 0, ..., ptr_i-1); the
// first set bit in that order wins.
//
// Parameters
//   N          number of requesters, N >= 1
// Ports
//   req_i      [N-1:0]      request vector
//   ptr_i      [IDX_W-1:0]  index with highest priority (must be < N)
//   win_oh_o   [N-1:0]      one-hot winner, all zeros when nothing requested
//   win_idx_o  [IDX_W-1:0]  binary winner index, 0 when nothing requested
//   any_o                   at least one request is set
// ---------------------------------------------------------------------------
module rot_prio_enc_n
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req_i,
  input  logic [idx_w(N)-1:0] ptr_i,
  output logic [N-1:0]        win_oh_o,
  output logic [idx_w(N)-1:0] win_idx_o,
  output logic                any_o
);

  localparam int IDX_W = idx_w(N);

  // Wrap is mod N, not mod 2^IDX_W: for non-power-of-2 N the search must
  // never land on the phantom indices N..2^IDX_W-1.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                input int               off);
    int sum;
    sum = int'(base) + off;
    if (sum >= N) sum = sum - N;
    return IDX_W'(sum);
  endfunction

  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned; that is what keeps this block latch-free.
    win_oh_o  = '0;
    win_idx_o = '0;
    any_o     = 1'b0;
    for (int off = 0; off < N; off++) begin
      if (!any_o && req_i[wrap_idx(ptr_i, off)]) begin
        any_o                          = 1'b1;
        win_idx_o                      = wrap_idx(ptr_i, off);
        win_oh_o[wrap_idx(ptr_i, off)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// rr_arbiter_n
// Round-robin arbiter for N requesters with a registered one-hot grant and
// binary grant index. A pointer register rotates priority so every
// requester is served fairly; outputs are pure registers (no combinational
// req-to-gnt path).
//
// Build option
//   ARB_LOCK_EN  when defined, the lock input and LOCKED state are active:
//                the current holder keeps its grant while req[w] && lock[w].
//                When undefined, lock is ignored and every grant lasts one
//                cycle.
//
// Parameters
//   N          number of requesters, N >= 1 (IDX_W derived, not overridable)
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req        [N-1:0]      level-sensitive requests
//   lock       [N-1:0]      burst hold per requester (ARB_LOCK_EN only)
//   gnt        [N-1:0]      registered one-hot grant, zero when no grant
//   gnt_valid               registered, equals |gnt
//   gnt_idx    [IDX_W-1:0]  registered binary index, 0 when gnt_valid is 0
// ---------------------------------------------------------------------------
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic [N-1:0]        lock,
  output logic [N-1:0]        gnt,
  output logic                gnt_valid,
  output logic [idx_w(N)-1:0] gnt_idx
);

  localparam int               IDX_W    = idx_w(N);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  arb_state_t       state_q, state_d;
  logic [N-1:0]     gnt_q,   gnt_d;
  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic [IDX_W-1:0] ptr_q,   ptr_d;

  logic [N-1:0]     win_oh;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             hold;

  rot_prio_enc_n #(
    .N (N)
  ) u_enc (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .win_oh_o  (win_oh),
    .win_idx_o (win_idx),
    .any_o     (win_any)
  );

`ifdef ARB_LOCK_EN
  // The registered winner keeps the resource while it both still requests
  // and still asserts lock; dropping either one re-arbitrates this cycle.
  assign hold = (state_q != IDLE) && req[idx_q] && lock[idx_q];
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign hold        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;

    if (!hold) begin
      if (win_any) begin
        state_d = GRANT;
        gnt_d   = win_oh;
        valid_d = 1'b1;
        idx_d   = win_idx;
        // Next search starts just past the winner, wrapping at N-1.
        ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        idx_d   = '0;
      end
    end
`ifdef ARB_LOCK_EN
    else begin
      // Grant and pointer stay frozen for the whole burst.
      state_d = LOCKED;
    end
`endif
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;
  assign gnt_idx   = idx_q;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// ---------------------------------------------------------------------------
// tb_rr_arbiter_n
// Three arbiter instances (N=4, N=5, N=1) share clock and reset. Directed
// scenarios check fixed grant sequences; a randomized phase compares every
// instance each cycle against a behavioural model that keeps only the
// current holder and the next-priority index as integers.
// ---------------------------------------------------------------------------
module tb_rr_arbiter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] req4, lock4, gnt4;
  logic       v4;
  logic [1:0] idx4;
  logic [4:0] req5, lock5, gnt5;
  logic       v5;
  logic [2:0] idx5;
  logic [0:0] req1, lock1, gnt1;
  logic       v1;
  logic [0:0] idx1;

  rr_arbiter_n #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .req(req4), .lock(lock4),
                                .gnt(gnt4), .gnt_valid(v4), .gnt_idx(idx4));
  rr_arbiter_n #(.N(5)) u_dut5 (.clk(clk), .rst(rst), .req(req5), .lock(lock5),
                                .gnt(gnt5), .gnt_valid(v5), .gnt_idx(idx5));
  rr_arbiter_n #(.N(1)) u_dut1 (.clk(clk), .rst(rst), .req(req1), .lock(lock1),
                                .gnt(gnt1), .gnt_valid(v1), .gnt_idx(idx1));

  int n_cmp = 0;
  int n_err = 0;

  // Model state per instance: [0]=N4, [1]=N5, [2]=N1. cur = -1 means no grant.
  int m_cur [3];
  int m_ptr [3];

  // One arbitration decision taken straight from the rules: a locked holder
  // keeps the grant, otherwise scan (ptr + k) mod n for the first request.
  function automatic void model_step(input int n, input logic [7:0] r, input logic [7:0] l,
                                     input int cur, input int ptr,
                                     output int ncur, output int nptr);
    ncur = -1;
    nptr = ptr;
`ifdef ARB_LOCK_EN
    if (cur >= 0 && r[cur] && l[cur]) begin
      ncur = cur;
      return;
    end
`endif
    for (int k = 0; k < n; k++) begin
      int c;
      c = (ptr + k) % n;
      if (r[c]) begin
        ncur = c;
        nptr = (c + 1) % n;
        return;
      end
    end
  endfunction

  function automatic logic [6:0] exp4();
    if (m_cur[0] < 0) return '0;
    return {4'(1 << m_cur[0]), 1'b1, 2'(m_cur[0])};
  endfunction

  function automatic logic [8:0] exp5();
    if (m_cur[1] < 0) return '0;
    return {5'(1 << m_cur[1]), 1'b1, 3'(m_cur[1])};
  endfunction

  function automatic logic [2:0] exp1();
    if (m_cur[2] < 0) return '0;
    return 3'b110;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_cur[i] = -1;
      m_ptr[i] = 0;
    end
  endtask

  task automatic clear_inputs();
    req4 = '0; lock4 = '0; req5 = '0; lock5 = '0; req1 = '0; lock1 = '0;
  endtask

  // Advance one edge: models consume the inputs sampled at that edge, then
  // outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_step(4, 8'(req4), 8'(lock4), m_cur[0], m_ptr[0], m_cur[0], m_ptr[0]);
    model_step(5, 8'(req5), 8'(lock5), m_cur[1], m_ptr[1], m_cur[1], m_ptr[1]);
    model_step(1, 8'(req1), 8'(lock1), m_cur[2], m_ptr[2], m_cur[2], m_ptr[2]);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req4 = '1; req5 = '1; req1 = '1;
    #1;
    n_cmp++;
    if ({gnt4, v4, idx4, gnt5, v5, idx5, gnt1, v1, idx1} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got %b %b %b, expected all zero",
               {gnt4, v4, idx4}, {gnt5, v5, idx5}, {gnt1, v1, idx1});
    end
    n_cmp++;
    if ({u_dut4.ptr_q, u_dut5.ptr_q} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ptr: got %b/%b, expected 0/0", u_dut4.ptr_q, u_dut5.ptr_q);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({gnt4, v4, idx4, gnt5, v5, idx5, gnt1, v1, idx1} !== '0) begin
      n_err++;
      $display("FAIL reset_held: got %b %b %b, expected all zero",
               {gnt4, v4, idx4}, {gnt5, v5, idx5}, {gnt1, v1, idx1});
    end
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_round_robin();
    do_reset();
    req4 = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if ({gnt4, v4, idx4} !== {4'(1 << (i % 4)), 1'b1, 2'(i % 4)}) begin
        n_err++;
        $display("FAIL rr_full cyc%0d: got gnt=%b v=%b idx=%0d, expected idx=%0d",
                 i, gnt4, v4, idx4, i % 4);
      end
    end
    req4 = '0;
    step();
    n_cmp++;
    if ({gnt4, v4, idx4} !== 7'b0) begin
      n_err++;
      $display("FAIL rr_idle: got gnt=%b v=%b idx=%0d, expected zero", gnt4, v4, idx4);
    end
  endtask

  task automatic test_alternate();
    do_reset();
    req4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i % 2 == 0) ? 1 : 3;
      step();
      n_cmp++;
      if ({gnt4, v4, idx4} !== {4'(1 << g), 1'b1, 2'(g)}) begin
        n_err++;
        $display("FAIL alternate cyc%0d: got gnt=%b idx=%0d, expected idx=%0d", i, gnt4, idx4, g);
      end
    end
  endtask

  task automatic test_n5_wrap();
    do_reset();
    req5 = 5'b10001;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (i % 2 == 0) ? 0 : 4;
      step();
      n_cmp++;
      if ({gnt5, v5, idx5, u_dut5.ptr_q} !== {5'(1 << g), 1'b1, 3'(g), 3'((g + 1) % 5)}) begin
        n_err++;
        $display("FAIL n5_ends cyc%0d: got gnt=%b idx=%0d ptr=%0d, expected idx=%0d ptr=%0d",
                 i, gnt5, idx5, u_dut5.ptr_q, g, (g + 1) % 5);
      end
    end
    req5 = 5'b11111;
    for (int i = 0; i < 6; i++) begin
      step();
      n_cmp++;
      if ({gnt5, v5, idx5, u_dut5.ptr_q} !== {5'(1 << (i % 5)), 1'b1, 3'(i % 5), 3'((i + 1) % 5)}) begin
        n_err++;
        $display("FAIL n5_full cyc%0d: got gnt=%b idx=%0d ptr=%0d, expected idx=%0d ptr=%0d",
                 i, gnt5, idx5, u_dut5.ptr_q, i % 5, (i + 1) % 5);
      end
    end
  endtask

  task automatic test_n1();
    logic [4:0] seq;
    seq = 5'b01101;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      req1 = seq[i];
      step();
      n_cmp++;
      if ({gnt1, v1, idx1} !== {seq[i], seq[i], 1'b0}) begin
        n_err++;
        $display("FAIL n1 cyc%0d: got gnt=%b v=%b idx=%b, expected gnt=%b v=%b idx=0",
                 i, gnt1, v1, idx1, seq[i], seq[i]);
      end
    end
  endtask

  task automatic test_lock();
`ifdef ARB_LOCK_EN
    do_reset();
    req4  = 4'b0011;
    lock4 = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if ({gnt4, v4, idx4} !== 7'b0001_1_00) begin
        n_err++;
        $display("FAIL lock_hold cyc%0d: got gnt=%b idx=%0d, expected gnt=0001", i, gnt4, idx4);
      end
    end
    n_cmp++;
    if (u_dut4.ptr_q !== 2'd1) begin
      n_err++;
      $display("FAIL lock_ptr: got %0d, expected 1", u_dut4.ptr_q);
    end
    lock4 = 4'b0000;
    step();
    n_cmp++;
    if ({gnt4, v4, idx4} !== 7'b0010_1_01) begin
      n_err++;
      $display("FAIL lock_release: got gnt=%b idx=%0d, expected idx=1", gnt4, idx4);
    end
    // Lock drops in the same cycle requester 2 appears: 2 must be eligible.
    do_reset();
    req4  = 4'b0001;
    lock4 = 4'b0001;
    step();
    step();
    req4  = 4'b0101;
    lock4 = 4'b0000;
    step();
    n_cmp++;
    if ({gnt4, v4, idx4} !== 7'b0100_1_10) begin
      n_err++;
      $display("FAIL lock_same_cycle: got gnt=%b idx=%0d, expected idx=2", gnt4, idx4);
    end
`else
    do_reset();
    req4  = 4'b0011;
    lock4 = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if ({gnt4, v4, idx4} !== {4'(1 << (i % 2)), 1'b1, 2'(i % 2)}) begin
        n_err++;
        $display("FAIL lock_ignored cyc%0d: got gnt=%b idx=%0d, expected idx=%0d",
                 i, gnt4, idx4, i % 2);
      end
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    req4  = 4'b0010;
    lock4 = 4'b0010;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt4, v4, idx4, u_dut4.ptr_q} !== 9'b0) begin
      n_err++;
      $display("FAIL reset_mid: got gnt=%b v=%b idx=%0d ptr=%0d, expected zero",
               gnt4, v4, idx4, u_dut4.ptr_q);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req4  = 4'b1111;
    lock4 = 4'b0000;
    step();
    n_cmp++;
    if ({gnt4, v4, idx4} !== 7'b0001_1_00) begin
      n_err++;
      $display("FAIL reset_mid_first: got gnt=%b idx=%0d, expected idx=0", gnt4, idx4);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req4  = 4'($urandom);
      lock4 = 4'($urandom) | 4'($urandom);
      req5  = ($urandom_range(0, 3) == 0) ? 5'($urandom) & 5'($urandom) : 5'($urandom);
      lock5 = 5'($urandom) | 5'($urandom);
      req1  = 1'($urandom);
      lock1 = 1'($urandom);
      step();
      n_cmp++;
      if ({gnt4, v4, idx4} !== exp4() || u_dut4.ptr_q !== 2'(m_ptr[0])) begin
        n_err++;
        $display("FAIL rand_n4 cyc%0d: got %b ptr=%0d, expected %b ptr=%0d",
                 i, {gnt4, v4, idx4}, u_dut4.ptr_q, exp4(), m_ptr[0]);
      end
      n_cmp++;
      if ({gnt5, v5, idx5} !== exp5() || u_dut5.ptr_q !== 3'(m_ptr[1])) begin
        n_err++;
        $display("FAIL rand_n5 cyc%0d: got %b ptr=%0d, expected %b ptr=%0d",
                 i, {gnt5, v5, idx5}, u_dut5.ptr_q, exp5(), m_ptr[1]);
      end
      n_cmp++;
      if ({gnt1, v1, idx1} !== exp1()) begin
        n_err++;
        $display("FAIL rand_n1 cyc%0d: got %b, expected %b", i, {gnt1, v1, idx1}, exp1());
      end
    end
  endtask

  initial begin
    clear_inputs();
    model_reset();
    test_reset();
    test_round_robin();
    test_alternate();
    test_n5_wrap();
    test_n1();
    test_lock();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
